// File: rtl/cache_control.sv
// Control FSM for a 2-way write-back L1: hit service, dirty-victim writeback, line allocate.
// Hits complete in the request cycle; misses stall the CPU until pmem_resp then replay as a hit.
module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic                 hit0,
    input  logic                 hit1,
    input  logic                 valid0,
    input  logic                 valid1,
    input  logic                 dirty0,
    input  logic                 dirty1,
    input  logic                 lru_out,
    output logic                 lru_load,
    output logic                 lru_tag0_hit,
    output logic                 lru_tag1_hit,
    output logic [1:0]           load_way,
    output logic                 data_sel,
    output logic                 set_dirty,
    output logic                 clr_dirty,
    output logic                 victim,
    output logic                 pmem_addr_sel,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic                 victim_q, victim_d;
    logic                 missed_q, missed_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    logic req;
    logic hit;
    logic victim_dirty;

    assign req          = mem_read | mem_write;
    assign hit          = hit0 | hit1;
    assign victim_dirty = lru_out ? (valid1 & dirty1) : (valid0 & dirty0);

    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        missed_d      = missed_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        mem_resp      = 1'b0;
        lru_load      = 1'b0;
        lru_tag0_hit  = 1'b0;
        lru_tag1_hit  = 1'b0;
        load_way      = 2'b00;
        data_sel      = 1'b0;
        set_dirty     = 1'b0;
        clr_dirty     = 1'b0;
        pmem_addr_sel = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req && hit) begin
                    mem_resp     = 1'b1;
                    lru_load     = 1'b1;
                    // Way 0 takes priority if the datapath ever reports both ways hit.
                    lru_tag0_hit = hit0;
                    lru_tag1_hit = hit1 & ~hit0;
                    if (mem_write) begin
                        load_way  = hit0 ? 2'b01 : 2'b10;
                        set_dirty = 1'b1;
                    end
                    // The replay hit after a fill belongs to the miss already counted.
                    if (missed_q) begin
                        missed_d = 1'b0;
                    end else if (!(&hit_cnt_q)) begin
                        hit_cnt_d = hit_cnt_q + CNT_ONE;
                    end
                end else if (req) begin
                    victim_d = lru_out;
                    missed_d = 1'b1;
                    if (!(&miss_cnt_q)) begin
                        miss_cnt_d = miss_cnt_q + CNT_ONE;
                    end
                    state_d = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                if (pmem_resp) begin
                    clr_dirty = 1'b1;
                    state_d   = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    load_way = victim_q ? 2'b10 : 2'b01;
                    data_sel = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cnt_clr) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end

        // Strobes must drop the instant reset asserts, without waiting for a clock.
        if (!rst_n) begin
            mem_resp      = 1'b0;
            lru_load      = 1'b0;
            lru_tag0_hit  = 1'b0;
            lru_tag1_hit  = 1'b0;
            load_way      = 2'b00;
            data_sel      = 1'b0;
            set_dirty     = 1'b0;
            clr_dirty     = 1'b0;
            pmem_addr_sel = 1'b0;
            pmem_read     = 1'b0;
            pmem_write    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            victim_q   <= 1'b0;
            missed_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            missed_q   <= missed_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign victim     = victim_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule
